median_block_scheduler: RTL and testbench

//  Frame-level sequencer for the median-filter read/write path. Walks a frame stored as
//  64-bit words (4 x 16-bit pixels/word) and issues one 3-row block fetch per word column
//  to the pixel reader. It then waits for the filter result and writes it to the output

---
 rtl/median_block_scheduler_pkg.sv | 14 +
 rtl/median_block_scheduler_if.sv | 20 ++
 rtl/median_block_scheduler_addr_gen.sv | 42 ++++
 rtl/median_block_scheduler.sv | 102 ++++++++++
 tb/tb_median_block_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/median_block_scheduler_pkg.sv
// median_pkg: shared FSM encodings and constants for the median-filter block scheduler.
package median_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_ISSUE    = 3'd1;
  localparam state_t S_WAIT_RD  = 3'd2;
  localparam state_t S_WAIT_FLT = 3'd3;
  localparam state_t S_WRITE    = 3'd4;
  localparam state_t S_ADVANCE  = 3'd5;
  localparam int PIX_PER_WORD = 4;
  localparam logic [7:0] WEN_ALL = 8'hFF;
  localparam int RBASE_DEF = 0;
  localparam int WBASE_DEF = 1097152;
endpackage

// File: rtl/median_block_scheduler_if.sv
// median_block_scheduler_if: host control, reader/filter handshake and SRAM write bundle.
interface median_block_scheduler_if #(parameter int AW = 21, parameter int BW = 8);
  logic          frame_start;
  logic [15:0]   frame_width;
  logic [15:0]   frame_height;
  logic          read_finish;
  logic          flt_valid;
  logic          read_start;
  logic [AW-1:0] block_adr;
  logic          right_edge;
  logic [AW-1:0] w_adr;
  logic [BW-1:0] wen;
  logic          busy;
  logic          frame_done;
  logic          err;
  modport master (output frame_start, frame_width, frame_height, read_finish, flt_valid,
                  input read_start, block_adr, right_edge, w_adr, wen, busy, frame_done, err);
  modport slave  (input frame_start, frame_width, frame_height, read_finish, flt_valid,
                  output read_start, block_adr, right_edge, w_adr, wen, busy, frame_done, err);
endinterface

// File: rtl/median_block_scheduler_addr_gen.sv
// median_addr_gen: row/col walker; row*wpr kept as a running base so no multiplier is needed.
module median_addr_gen #(
  parameter int AW    = 21,
  parameter int RBASE = 0,
  parameter int WBASE = 1097152
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [15:0]   wpr,
  input  logic [15:0]   rows_out,
  output logic [AW-1:0] block_adr,
  output logic [AW-1:0] w_adr,
  output logic          right_edge,
  output logic          last
);
  logic [15:0]   row_q, row_d, col_q, col_d;
  logic [AW-1:0] base_q, base_d;
  logic          wrap;
  assign right_edge = col_q == wpr - 16'd1;
  assign last       = right_edge && row_q == rows_out - 16'd1;
  assign wrap       = adv && right_edge;
  assign block_adr  = AW'(RBASE) + base_q + AW'(col_q);
  assign w_adr      = AW'(WBASE) + base_q + AW'(col_q);
  always_comb begin
    col_d  = (clr || wrap) ? '0 : col_q + 16'(adv);
    row_d  = clr ? '0 : row_q + 16'(wrap);
    base_d = clr ? '0 : base_q + (wrap ? AW'(wpr) : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      base_q <= base_d;
    end
  end
endmodule

// File: rtl/median_block_scheduler.sv
// median_block_scheduler: walks a frame one 3-row word block at a time, fetch -> filter -> write.
module median_block_scheduler
  import median_pkg::*;
#(
  parameter int AW    = 21,
  parameter int BW    = 8,
  parameter int RBASE = RBASE_DEF,
  parameter int WBASE = WBASE_DEF,
  parameter int TO_W  = 10
) (
  input logic pclk,
  input logic prst,
  median_block_scheduler_if.slave bus
);
  state_t            state_q, state_d;
  logic              rd_q, rd_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic [15:0]       wpr_q, wpr_d, rows_q, rows_d, wpr_in;
  logic              bad, clr, adv, last, to_exp;
  logic [AW-1:0]     w_adr_raw;
  assign wpr_in = bus.frame_width >> 2;
  assign bad    = wpr_in == 16'd0 || bus.frame_height < 16'd3;
  assign to_inc = to_q + 1'b1;
  assign to_exp = &to_inc;
  median_addr_gen #(.AW(AW), .RBASE(RBASE), .WBASE(WBASE)) u_addr (
    .clk(pclk), .rst(prst), .clr(clr), .adv(adv), .wpr(wpr_q), .rows_out(rows_q),
    .block_adr(bus.block_adr), .w_adr(w_adr_raw), .right_edge(bus.right_edge), .last(last)
  );
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    to_d    = to_q;
    wpr_d   = wpr_q;
    rows_d  = rows_q;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: if (bus.frame_start) begin
        clr     = 1'b1;
        wpr_d   = wpr_in;
        rows_d  = bus.frame_height - 16'd2;
        err_d   = bad;
        done_d  = bad;
        busy_d  = !bad;
        state_d = bad ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        rd_d    = 1'b1;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: if (bus.read_finish) begin
        rd_d    = 1'b0;
        to_d    = '0;
        state_d = S_WAIT_FLT;
      end
      // a result arriving on the expiry cycle still counts as on time
      S_WAIT_FLT: begin
        to_d    = (bus.flt_valid || to_exp) ? '0 : to_inc;
        err_d   = err_q | (!bus.flt_valid && to_exp);
        state_d = bus.flt_valid ? S_WRITE : to_exp ? S_ADVANCE : S_WAIT_FLT;
      end
      S_WRITE: state_d = S_ADVANCE;
      S_ADVANCE: begin
        adv     = 1'b1;
        busy_d  = !last;
        done_d  = last;
        state_d = last ? S_IDLE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
      wpr_q   <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
      wpr_q   <= wpr_d;
      rows_q  <= rows_d;
    end
  end
  assign bus.read_start = rd_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.err        = err_q;
  assign bus.wen        = (state_q == S_WRITE) ? BW'(WEN_ALL) : '0;
  assign bus.w_adr      = (state_q == S_WRITE) ? w_adr_raw : '0;
endmodule

// File: tb/tb_median_block_scheduler.sv
// tb_median_block_scheduler: scoreboarded scenarios with reader/filter models around the scheduler.
module tb_median_block_scheduler;
  import median_pkg::*;
  localparam int AW = 21;
  localparam int WB = 1097152;
  typedef struct {logic [AW-1:0] adr; logic re;} blk_t;
  logic pclk = 1'b0;
  logic prst = 1'b1;
  median_block_scheduler_if #(.AW(AW), .BW(8)) bus();
  median_block_scheduler #(.AW(AW), .BW(8), .RBASE(0), .WBASE(WB), .TO_W(4)) dut (
    .pclk(pclk), .prst(prst), .bus(bus)
  );
  always #5 pclk = ~pclk;
  int total = 0;
  int bad = 0;
  logic rf_m = 1'b0, flt_m = 1'b0, flt_inj = 1'b0, prev_rs = 1'b0, mon_rs = 1'b0;
  bit flt_auto = 1'b1;
  int rcnt = 0, fcnt = 0;
  assign bus.read_finish = rf_m;
  assign bus.flt_valid   = flt_m | flt_inj;
  // reader finishes 6 cycles after read_start; filter pulses 3 cycles after the reader hands off
  always @(negedge pclk) begin
    if (prst) begin
      rcnt = 0; fcnt = 0; rf_m = 1'b0; flt_m = 1'b0; prev_rs = 1'b0;
    end else begin
      flt_m = 1'b0;
      if (bus.read_start) begin
        rcnt++;
        if (rcnt >= 6) rf_m = 1'b1;
      end else begin
        rcnt = 0;
        rf_m = 1'b0;
      end
      if (prev_rs && !bus.read_start) fcnt = flt_auto ? 3 : 0;
      else if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) flt_m = 1'b1;
      end
      prev_rs = bus.read_start;
    end
  end
  blk_t exp_blk[$];
  logic [AW-1:0] exp_wr[$];
  blk_t eb;
  logic [AW-1:0] ea;
  int rd_rises = 0, wr_cnt = 0, done_cnt = 0;
  bit busy_seen = 1'b0;
  always @(negedge pclk) begin
    if (prst) mon_rs = 1'b0;
    else begin
      if (bus.read_start && !mon_rs) begin
        rd_rises++;
        total++;
        if (exp_blk.size() == 0) begin
          bad++;
          $display("FAIL blk_issue: unexpected block_adr=%0d", bus.block_adr);
        end else begin
          eb = exp_blk.pop_front();
          if (bus.block_adr !== eb.adr || bus.right_edge !== eb.re) begin
            bad++;
            $display("FAIL blk_issue: got adr=%0d re=%b want adr=%0d re=%b", bus.block_adr, bus.right_edge, eb.adr, eb.re);
          end
        end
      end
      if (bus.wen !== 8'h00) begin
        wr_cnt++;
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL write: unexpected w_adr=%0d wen=%h", bus.w_adr, bus.wen);
        end else begin
          ea = exp_wr.pop_front();
          if (bus.w_adr !== ea || bus.wen !== WEN_ALL) begin
            bad++;
            $display("FAIL write: got w_adr=%0d wen=%h want w_adr=%0d wen=ff", bus.w_adr, bus.wen, ea);
          end
        end
      end
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) busy_seen = 1'b1;
      mon_rs = bus.read_start;
    end
  end
  task automatic push_frame(input int w, input int h);
    int wpr = w / 4;
    for (int r = 0; r < h - 2; r++)
      for (int c = 0; c < wpr; c++) begin
        blk_t e;
        e.adr = AW'(r * wpr + c);
        e.re  = (c == wpr - 1);
        exp_blk.push_back(e);
        exp_wr.push_back(AW'(WB + r * wpr + c));
      end
  endtask
  task automatic clear_counts();
    rd_rises = 0; wr_cnt = 0; done_cnt = 0; busy_seen = 1'b0;
  endtask
  task automatic start_frame(input int w, input int h);
    @(negedge pclk);
    bus.frame_width  = 16'(w);
    bus.frame_height = 16'(h);
    bus.frame_start  = 1'b1;
    @(negedge pclk);
    bus.frame_start  = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    repeat (3) @(negedge pclk);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge pclk);
    total++; if (bus.read_start !== 1'b0) begin bad++; $display("FAIL rst_read_start: got %b want 0", bus.read_start); end
    total++; if (bus.block_adr !== '0) begin bad++; $display("FAIL rst_block_adr: got %0d want 0", bus.block_adr); end
    total++; if (bus.right_edge !== 1'b0) begin bad++; $display("FAIL rst_right_edge: got %b want 0", bus.right_edge); end
    total++; if (bus.w_adr !== '0) begin bad++; $display("FAIL rst_w_adr: got %0d want 0", bus.w_adr); end
    total++; if (bus.wen !== 8'h00) begin bad++; $display("FAIL rst_wen: got %h want 00", bus.wen); end
    total++; if ({bus.busy, bus.frame_done, bus.err} !== 3'b000) begin bad++; $display("FAIL rst_status: got %b want 000", {bus.busy, bus.frame_done, bus.err}); end
    prst = 1'b0;
  endtask
  task automatic test_basic();
    bit ok;
    clear_counts();
    push_frame(8, 4);
    start_frame(8, 4);
    total++; if (bus.read_start !== 1'b0) begin bad++; $display("FAIL latency_early: got %b want 0", bus.read_start); end
    @(negedge pclk);
    total++; if (bus.read_start !== 1'b1) begin bad++; $display("FAIL latency_2cyc: got %b want 1", bus.read_start); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done: got no frame_done want pulse"); end
    total++; if (wr_cnt !== 4 || rd_rises !== 4) begin bad++; $display("FAIL basic_counts: got wr=%0d rd=%0d want 4 4", wr_cnt, rd_rises); end
    total++; if (done_cnt !== 1 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL basic_end: got done=%0d busy=%b err=%b want 1 0 0", done_cnt, bus.busy, bus.err); end
  endtask
  task automatic test_bad_dims();
    int ws[2] = '{2, 8};
    int hs[2] = '{4, 2};
    bit ok;
    for (int k = 0; k < 2; k++) begin
      clear_counts();
      start_frame(ws[k], hs[k]);
      wait_done(ok);
      total++; if (!ok || done_cnt !== 1) begin bad++; $display("FAIL bad_dims_done: w=%0d h=%0d got done=%0d want 1", ws[k], hs[k], done_cnt); end
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL bad_dims_err: w=%0d h=%0d got %b want 1", ws[k], hs[k], bus.err); end
      total++; if (rd_rises !== 0 || busy_seen !== 1'b0) begin bad++; $display("FAIL bad_dims_quiet: got rd=%0d busy_seen=%b want 0 0", rd_rises, busy_seen); end
    end
  endtask
  task automatic test_timeout();
    bit ok;
    bit seen = 1'b0;
    int n = 0;
    flt_auto = 1'b0;
    clear_counts();
    push_frame(8, 3);
    exp_wr.delete();
    start_frame(8, 3);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge pclk);
      if (bus.read_start === 1'b1) seen = 1'b1;
    end
    for (int i = 0; i < 100 && bus.read_start === 1'b1; i++) @(negedge pclk);
    for (int i = 0; i < 100 && bus.err !== 1'b1; i++) begin
      n++;
      @(negedge pclk);
    end
    total++; if (!seen || n !== 15) begin bad++; $display("FAIL timeout_cycles: got %0d want 15", n); end
    wait_done(ok);
    total++; if (!ok || done_cnt !== 1) begin bad++; $display("FAIL timeout_done: got done=%0d want 1", done_cnt); end
    total++; if (wr_cnt !== 0 || rd_rises !== 2 || bus.err !== 1'b1) begin bad++; $display("FAIL timeout_end: got wr=%0d rd=%0d err=%b want 0 2 1", wr_cnt, rd_rises, bus.err); end
    flt_auto = 1'b1;
  endtask
  task automatic test_single();
    bit ok;
    clear_counts();
    push_frame(4, 3);
    start_frame(4, 3);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", bus.err); end
    wait_done(ok);
    total++; if (!ok || done_cnt !== 1 || wr_cnt !== 1 || rd_rises !== 1) begin bad++; $display("FAIL single: got done=%0d wr=%0d rd=%0d want 1 1 1", done_cnt, wr_cnt, rd_rises); end
  endtask
  task automatic test_ignored();
    bit ok;
    bit seen = 1'b0;
    clear_counts();
    push_frame(8, 4);
    start_frame(8, 4);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge pclk);
      if (bus.read_start === 1'b1) seen = 1'b1;
    end
    @(negedge pclk);
    flt_inj = 1'b1;
    bus.frame_width = 16'd4;
    bus.frame_height = 16'd3;
    bus.frame_start = 1'b1;
    @(negedge pclk);
    flt_inj = 1'b0;
    bus.frame_start = 1'b0;
    wait_done(ok);
    total++; if (!seen || !ok || done_cnt !== 1) begin bad++; $display("FAIL ignored_done: got seen=%b done=%0d want 1 1", seen, done_cnt); end
    total++; if (wr_cnt !== 4 || rd_rises !== 4 || bus.err !== 1'b0) begin bad++; $display("FAIL ignored_counts: got wr=%0d rd=%0d err=%b want 4 4 0", wr_cnt, rd_rises, bus.err); end
  endtask
  task automatic test_reset_mid();
    bit ok;
    clear_counts();
    push_frame(8, 4);
    start_frame(8, 4);
    for (int i = 0; i < 200 && rd_rises < 2; i++) @(negedge pclk);
    repeat (2) @(negedge pclk);
    prst = 1'b1;
    #1;
    total++; if ({bus.read_start, bus.busy, bus.frame_done, bus.err, bus.right_edge} !== 5'b0) begin bad++; $display("FAIL midrst_ctrl: got %b want 00000", {bus.read_start, bus.busy, bus.frame_done, bus.err, bus.right_edge}); end
    total++; if (bus.block_adr !== '0 || bus.w_adr !== '0 || bus.wen !== 8'h00) begin bad++; $display("FAIL midrst_addr: got blk=%0d w=%0d wen=%h want 0 0 00", bus.block_adr, bus.w_adr, bus.wen); end
    total++; if (rd_rises !== 2 || wr_cnt !== 1) begin bad++; $display("FAIL midrst_progress: got rd=%0d wr=%0d want 2 1", rd_rises, wr_cnt); end
    exp_blk.delete();
    exp_wr.delete();
    @(negedge pclk);
    prst = 1'b0;
    clear_counts();
    push_frame(8, 4);
    start_frame(8, 4);
    wait_done(ok);
    total++; if (!ok || done_cnt !== 1 || wr_cnt !== 4 || rd_rises !== 4) begin bad++; $display("FAIL midrst_restart: got done=%0d wr=%0d rd=%0d want 1 4 4", done_cnt, wr_cnt, rd_rises); end
  endtask
  initial begin
    bus.frame_start  = 1'b0;
    bus.frame_width  = 16'd0;
    bus.frame_height = 16'd0;
    test_reset();
    test_basic();
    test_bad_dims();
    test_timeout();
    test_single();
    test_ignored();
    test_reset_mid();
    total++; if (exp_blk.size() != 0 || exp_wr.size() != 0) begin bad++; $display("FAIL leftover: got blk=%0d wr=%0d want 0 0", exp_blk.size(), exp_wr.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
